// File: rtl/ase_pkg.sv
// Shared CCI-P header types for the ASE request/response stream models,
// including the entry layout and response codes used by the stream responder.
package ase_pkg;

  localparam logic [3:0] ASE_WRLINE_I = 4'h1;
  localparam logic [3:0] ASE_WRLINE_M = 4'h2;
  localparam logic [3:0] ASE_RDLINE_I = 4'h4;
  localparam logic [3:0] ASE_WRFENCE  = 4'h5;
  localparam logic [3:0] ASE_RDLINE_S = 4'h6;

  localparam logic [3:0] ASE_RD_RSP = 4'h0;
  localparam logic [3:0] ASE_WR_RSP = 4'h1;

  localparam int ASE_RSP_TS_WIDTH = 16;
  localparam int ASE_TID_WIDTH    = 32;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  reqtype;
    logic [1:0]  len;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [3:0]  resptype;
    logic [1:0]  clnum;
    logic [15:0] mdata;
  } RxHdr_t;

  typedef struct packed {
    TxHdr_t                        hdr;
    logic [ASE_TID_WIDTH-1:0]      tid;
    logic [ASE_RSP_TS_WIDTH-1:0]   ts;
  } ase_rsp_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } ase_rsp_state_t;

  function automatic logic is_read(input logic [3:0] reqtype);
    return (reqtype == ASE_RDLINE_I) || (reqtype == ASE_RDLINE_S);
  endfunction

endpackage

// File: rtl/ase_rsp_fifo.sv
// Circular request store for the stream responder: header, tid and acceptance
// timestamp per entry, with occupancy count and a registered accept-ready flag.
module ase_rsp_fifo
  import ase_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TID_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  TxHdr_t                        push_hdr,
  input  logic [TID_WIDTH-1:0]          push_tid,
  input  logic [ASE_RSP_TS_WIDTH-1:0]   push_ts,
  input  logic                          pop,
  output TxHdr_t                        head_hdr,
  output logic [TID_WIDTH-1:0]          head_tid,
  output logic [ASE_RSP_TS_WIDTH-1:0]   head_ts,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  TxHdr_t                        hdr_mem [DEPTH];
  logic [TID_WIDTH-1:0]          tid_mem [DEPTH];
  logic [ASE_RSP_TS_WIDTH-1:0]   ts_mem  [DEPTH];
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 rd_ptr;
  logic [AW:0]                   count_nxt;

  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_ptr] <= push_hdr;
      tid_mem[wr_ptr] <= push_tid;
      ts_mem[wr_ptr]  <= push_ts;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (!push && pop)
      count_nxt = count - (AW+1)'(1);
  end

  // ready reflects occupancy after this cycle's push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt < FULL_CNT);
    end
  end

  assign head_hdr = hdr_mem[rd_ptr];
  assign head_tid = tid_mem[rd_ptr];
  assign head_ts  = ts_mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/ase_stream_responder.sv
// Returns tagged RX response beats for buffered TX requests, in request order,
// once each request has aged at least LATENCY cycles.
module ase_stream_responder
  import ase_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TID_WIDTH = 32,
  parameter int LATENCY   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  TxHdr_t                hdr_in,
  input  logic [TID_WIDTH-1:0]  tid_in,
  output logic                  ready_in,
  output logic                  valid_out,
  output TxHdr_t                txhdr_out,
  output RxHdr_t                rxhdr_out,
  output logic [TID_WIDTH-1:0]  tid_out,
  output logic                  overflow_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ASE_RSP_TS_WIDTH-1:0] LAT_TS = ASE_RSP_TS_WIDTH'(LATENCY);

  logic [ASE_RSP_TS_WIDTH-1:0] tsc;
  logic                        push;
  logic                        pop;
  logic                        emit;
  TxHdr_t                      head_hdr;
  logic [TID_WIDTH-1:0]        head_tid;
  logic [ASE_RSP_TS_WIDTH-1:0] head_ts;
  logic                        empty;
  logic [CW-1:0]               count;
  logic                        elig;
  logic                        remain;
  logic [1:0]                  last_idx;
  logic [1:0]                  bcnt;
  logic [1:0]                  bcnt_nxt;
  ase_rsp_state_t              state;
  ase_rsp_state_t              state_nxt;

  assign push = valid_in && ready_in;

  ase_rsp_fifo #(
    .DEPTH     (DEPTH),
    .TID_WIDTH (TID_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_hdr (hdr_in),
    .push_tid (tid_in),
    .push_ts  (tsc),
    .pop      (pop),
    .head_hdr (head_hdr),
    .head_tid (head_tid),
    .head_ts  (head_ts),
    .empty    (empty),
    .count    (count),
    .ready    (ready_in)
  );

  // Modulo age compare stays valid across counter wrap since ages stay below 2^15
  assign elig     = !empty && ((tsc - head_ts) >= LAT_TS);
  assign last_idx = is_read(head_hdr.reqtype) ? head_hdr.len : 2'd0;
  assign remain   = (count > CW'(1)) || push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bcnt  <= 2'd0;
      tsc   <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      tsc   <= tsc + ASE_RSP_TS_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    emit      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (push || !empty) state_nxt = S_WAIT;
      S_WAIT:  if (elig) emit = 1'b1;
      S_BURST: emit = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    // Last beat pops the head so the next entry can start on the following edge
    if (emit) begin
      if (bcnt == last_idx) begin
        pop       = 1'b1;
        bcnt_nxt  = 2'd0;
        state_nxt = remain ? S_WAIT : S_IDLE;
      end else begin
        bcnt_nxt  = bcnt + 2'd1;
        state_nxt = S_BURST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      txhdr_out    <= '0;
      rxhdr_out    <= '0;
      tid_out      <= '0;
      overflow_err <= 1'b0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        txhdr_out          <= head_hdr;
        tid_out            <= head_tid;
        rxhdr_out.resptype <= is_read(head_hdr.reqtype) ? ASE_RD_RSP : ASE_WR_RSP;
        rxhdr_out.clnum    <= bcnt;
        rxhdr_out.mdata    <= head_hdr.mdata;
      end
      if (valid_in && !ready_in) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ase_stream_responder.sv
// Bench for ase_stream_responder: directed scenarios plus long random traffic,
// checked against a request-level schedule model.
module tb_ase_stream_responder;
  import ase_pkg::*;

  localparam int DEPTH = 4;
  localparam int TIDW  = 32;
  localparam int LAT   = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in;
  TxHdr_t          hdr_in;
  logic [TIDW-1:0] tid_in;
  logic            ready_in;
  logic            valid_out;
  TxHdr_t          txhdr_out;
  RxHdr_t          rxhdr_out;
  logic [TIDW-1:0] tid_out;
  logic            overflow_err;

  ase_stream_responder #(
    .DEPTH     (DEPTH),
    .TID_WIDTH (TIDW),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .hdr_in       (hdr_in),
    .tid_in       (tid_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .txhdr_out    (txhdr_out),
    .rxhdr_out    (rxhdr_out),
    .tid_out      (tid_out),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              c;
    TxHdr_t          hdr;
    logic [TIDW-1:0] tid;
    logic [1:0]      cl;
  } beat_t;

  beat_t exp_q[$];
  int    pop_q[$];
  int    cyc;
  int    next_free;
  bit    ready_m;
  bit    ovf_m;
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int nbeats(input TxHdr_t h);
    if (h.reqtype == ASE_RDLINE_I || h.reqtype == ASE_RDLINE_S) return int'(h.len) + 1;
    return 1;
  endfunction

  // Each request occupies the output from max(accept+LAT, end of previous burst)
  task automatic accept(input TxHdr_t h, input logic [TIDW-1:0] t);
    int n;
    int start;
    n = nbeats(h);
    start = (cyc + LAT > next_free) ? cyc + LAT : next_free;
    for (int i = 0; i < n; i++) exp_q.push_back('{start + i, h, t, 2'(i)});
    next_free = start + n;
    pop_q.push_back(start + n - 1);
  endtask

  task automatic check_cycle();
    beat_t b;
    if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      b = exp_q.pop_front();
      chk("valid_out", 64'(valid_out), 64'(1));
      chk("tid_out", 64'(tid_out), 64'(b.tid));
      chk("txhdr_out", 64'(txhdr_out), 64'(b.hdr));
      chk("clnum", 64'(rxhdr_out.clnum), 64'(b.cl));
      chk("mdata", 64'(rxhdr_out.mdata), 64'(b.hdr.mdata));
      chk("resptype", 64'(rxhdr_out.resptype),
          64'((nbeats(b.hdr) > 1 || b.hdr.reqtype == ASE_RDLINE_I ||
               b.hdr.reqtype == ASE_RDLINE_S) ? ASE_RD_RSP : ASE_WR_RSP));
    end else begin
      chk("valid_out_idle", 64'(valid_out), 64'(0));
    end
    chk("ready_in", 64'(ready_in), 64'(ready_m));
    chk("overflow_err", 64'(overflow_err), 64'(ovf_m));
  endtask

  task automatic step(input bit v, input TxHdr_t h, input logic [TIDW-1:0] t);
    valid_in = v;
    hdr_in   = h;
    tid_in   = t;
    @(posedge clk);
    cyc++;
    if (v && ready_m) accept(h, t);
    else if (v) ovf_m = 1'b1;
    while (pop_q.size() > 0 && pop_q[0] <= cyc) void'(pop_q.pop_front());
    ready_m = (pop_q.size() < DEPTH);
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    TxHdr_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, z, '0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_txhdr_out", 64'(txhdr_out), 64'(0));
    chk("rst_rxhdr_out", 64'(rxhdr_out), 64'(0));
    chk("rst_tid_out", 64'(tid_out), 64'(0));
    chk("rst_ready_in", 64'(ready_in), 64'(0));
    chk("rst_overflow_err", 64'(overflow_err), 64'(0));
    exp_q.delete();
    pop_q.delete();
    next_free = 0;
    ready_m = 1'b0;
    ovf_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_hold_ready_in", 64'(ready_in), 64'(0));
    end
    rst_n = 1'b1;
  endtask

  function automatic TxHdr_t mk(input logic [3:0] rt, input logic [1:0] len, input logic [15:0] md);
    TxHdr_t h;
    h.addr    = 16'(md * 7 + 3);
    h.reqtype = rt;
    h.len     = len;
    h.mdata   = md;
    return h;
  endfunction

  initial begin
    logic [3:0] types [5];
    TxHdr_t     h;
    types = '{ASE_WRLINE_I, ASE_WRLINE_M, ASE_RDLINE_I, ASE_WRFENCE, ASE_RDLINE_S};
    total = 0;
    bad = 0;
    cyc = 0;
    next_free = 0;
    valid_in = 1'b0;
    hdr_in = '0;
    tid_in = '0;
    rst_n = 1'b1;
    #2;
    do_reset();

    // single read, len=3
    idle(9);
    step(1'b1, mk(ASE_RDLINE_S, 2'd3, 16'h5), 32'h11);
    idle(14);

    // mixed back-to-back: write, read len=1, fence
    step(1'b1, mk(ASE_WRLINE_I, 2'd2, 16'h21), 32'h1);
    step(1'b1, mk(ASE_RDLINE_I, 2'd1, 16'h22), 32'h2);
    step(1'b1, mk(ASE_WRFENCE, 2'd0, 16'h23), 32'h3);
    idle(14);

    // overflow: five requests into a 4-deep store
    for (int i = 0; i < 5; i++) step(1'b1, mk(ASE_WRLINE_M, 2'd0, 16'(16'h30 + i)), 32'(32'h40 + i));
    idle(16);

    // reset while beat 2 of a len=3 read is presented
    step(1'b1, mk(ASE_RDLINE_S, 2'd3, 16'h77), 32'h99);
    idle(LAT + 2);
    chk("midburst_clnum", 64'(rxhdr_out.clnum), 64'(2));
    do_reset();
    idle(16);

    // push and pop together at occupancy DEPTH-1
    for (int i = 0; i < 3; i++) step(1'b1, mk(ASE_WRLINE_I, 2'd0, 16'(16'h50 + i)), 32'(32'h60 + i));
    idle(LAT - 3);
    step(1'b1, mk(ASE_WRLINE_I, 2'd0, 16'h53), 32'h63);
    step(1'b1, mk(ASE_RDLINE_I, 2'd2, 16'h54), 32'h64);
    idle(20);

    // long random traffic spanning a timestamp wrap
    for (int i = 0; i < 70000; i++) begin
      h.addr    = 16'($urandom);
      h.reqtype = types[$urandom_range(0, 4)];
      h.len     = 2'($urandom_range(0, 3));
      h.mdata   = 16'($urandom);
      step(($urandom_range(0, 3) == 0), h, $urandom);
    end
    idle(40);
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ase_stream_responder.md
# ase_stream_responder

Behavioural responder for the ASE CCI-P request stream. It accepts tagged TX request headers, holds each one for a fixed minimum latency, and then returns tagged RX response headers in request order. Read requests expand to one response beat per cacheline. Every other request type returns a single beat. The block sits on the far side of the request stream from the stream checker, so the checker's `valid_out`/`rxhdr_out`/`tid_out` inputs can be driven directly from this block.

## Interface
- `DEPTH`, default 16: request entries buffered, power of two, at least 2.
- `TID_WIDTH`, default 32: transaction-ID width.
- `LATENCY`, default 8: minimum cycles from request acceptance to its first response beat; range 1..32767.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  request present.
- `hdr_in`  in  TxHdr_t  request header (`reqtype`, `len`, `mdata` used).
- `tid_in`  in  TID_WIDTH  request transaction ID.
- `ready_in`  out  1  registered; the block can accept a request this cycle.
- `valid_out`  out  1  response beat valid.
- `txhdr_out`  out  TxHdr_t  original request header, echoed.
- `rxhdr_out`  out  RxHdr_t  response header.
- `tid_out`  out  TID_WIDTH  transaction ID of the response.
- `overflow_err`  out  1  sticky; a request was presented while `ready_in` was 0.

## Operation
- Accept rule: a request is accepted when `valid_in && ready_in`. It is written to a circular FIFO together with a 16-bit timestamp taken from a free-running cycle counter.
- `valid_in && !ready_in` drops the request and sets `overflow_err`. `overflow_err` clears only on reset.
- `ready_in` is 1 when, after this cycle's push and pop, the occupancy is below DEPTH.
- Head eligibility: the head entry is eligible when `(now - ts) mod 2^16 >= LATENCY`.
- FSM states are IDLE, WAIT and BURST.
  - IDLE → WAIT when the FIFO is non-empty.
  - WAIT → BURST when the head entry is eligible.
  - BURST emits one beat per cycle.
  - After the last beat, BURST → WAIT if another entry remains, otherwise BURST → IDLE.
- Read beats: for `reqtype` ASE_RDLINE_I or ASE_RDLINE_S, the block emits `len+1` beats.
  - `rxhdr_out.clnum` takes the values 0..len in order.
  - `resptype` is ASE_RD_RSP.
- Other request types emit one beat with `clnum=0` and `resptype=ASE_WR_RSP`. This includes ASE_WRFENCE.
- On every beat, `rxhdr_out.mdata = hdr_in.mdata` of the request, `tid_out` is the stored tid, and `txhdr_out` is the stored header.
- The FIFO pops in the cycle the last beat is presented.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Read/write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
- The timestamp counter wraps; the modulo comparison stays correct because LATENCY < 2^15 and no entry waits 2^15 cycles.
- Reset mid-burst: outputs go to their reset values immediately, the FIFO empties and the FSM returns to IDLE. No partial burst resumes.

## Timing
- All outputs are registered.
- Reset values: `valid_out=0`, `txhdr_out=0`, `rxhdr_out=0`, `tid_out=0`, `ready_in=0`, `overflow_err=0`, timestamp counter = 0.
- `ready_in` rises the first clock after `rst_n` deasserts.
- A request accepted at edge T into an empty, idle block has its first beat valid in cycle T+LATENCY.
- A read with `len=3` occupies cycles T+LATENCY .. T+LATENCY+3.
- Sustained throughput is one beat per cycle when entries are already eligible; there are no bubbles between consecutive bursts.
- There is no output backpressure; the consumer must take every beat.

## Structure
- The `ase_pkg` additions are:
  - response type constants ASE_RD_RSP and ASE_WR_RSP;
  - typedef `ase_rsp_entry_t` = {TxHdr_t hdr; logic [TID_WIDTH-1:0] tid; logic [15:0] ts};
  - the constant `ASE_RSP_TS_WIDTH = 16`.
- Sub-module `ase_rsp_fifo` holds the parameterised storage, pointers, count and `ready_in`.
- The top level holds the timestamp counter, the FSM and the beat counter.

## Test plan
- Single read: `RDLINE_S`, `len=3`, `tid=0x11`, `mdata=0x5`, LATENCY=8, accepted at cycle 10. Required: beats at cycles 18–21 with `clnum` 0,1,2,3, `tid_out=0x11`, `mdata=0x5`.
- Mixed back-to-back: write `tid=1`, then read `len=1` `tid=2`, then `WRFENCE` `tid=3`, on consecutive cycles. Required: four contiguous beats in order (1/0), (2/0), (2/1), (3/0), with no bubbles.
- Overflow: DEPTH=4, five requests on consecutive cycles with no drain possible. Required: `ready_in` is 0 on the fifth cycle, `overflow_err=1`, and only four responses emerge.
- Wrap: run 70000 cycles of random traffic through the stream checker. Required: no "not found" messages, and every response arrives at least LATENCY cycles after its request.
- Reset mid-burst: assert `rst_n=0` during beat 2 of a `len=3` read. Required: `valid_out=0` immediately, and no beats for that request after release.
- Simultaneous push/pop at a FIFO occupancy of DEPTH-1. Required: `ready_in` stays 1 and no data is lost.
